// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SZ_HALF) && off[0])
        || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return {{24{~uns & b[7]}}, b};
      SZ_HALF: return {{16{~uns & h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response handshake bundle between core and data memory.
interface dmem_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i,
    output req_wdata_i, req_size_i, req_unsigned_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i,
    input  req_wdata_i, req_size_i, req_unsigned_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane enables, store replication and load extraction.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rdata
);

  always_comb begin
    be   = 4'b0000;
    wrep = wdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata[7:0]}};
      end
      size == SZ_HALF: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      size == SZ_WORD: be = 4'b1111;
      default:         be = 4'b0000;
    endcase
  end

  assign rdata = load_ext(word, off, size, uns);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder over valid/ready.
// Optional DMEM_STATS_EN adds saturating read/write/error counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dmem_if.slave       bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] err_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_RESP = RESP;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  st;
  logic [3:0]  cnt;
  logic        cap_write, cap_uns;
  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_size;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, hs, do_access;
  logic        a_write, a_uns, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [AW-1:0] a_idx;
  logic [3:0]  be;
  logic [31:0] wrep, ldata, rword;

  assign accept = (st == S_IDLE) & bus.req_ready_o & bus.req_valid_i;
  assign hs     = (st == S_RESP) & bus.rsp_valid_o & bus.rsp_ready_i;
  assign do_access = (accept & (LATENCY == 1))
                   | ((st == S_WAIT) & (cnt == 4'd1));

  // With LATENCY==1 the access happens on the accept edge itself.
  assign a_write = (st == S_IDLE) ? bus.req_write_i    : cap_write;
  assign a_uns   = (st == S_IDLE) ? bus.req_unsigned_i : cap_uns;
  assign a_addr  = (st == S_IDLE) ? bus.req_addr_i     : cap_addr;
  assign a_wdata = (st == S_IDLE) ? bus.req_wdata_i    : cap_wdata;
  assign a_size  = (st == S_IDLE) ? bus.req_size_i     : cap_size;

  assign a_err = (a_size == 2'b11)
               | misaligned(a_size, a_addr[1:0])
               | ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign a_idx = a_addr[AW+1:2];
  assign rword = mem[a_idx];

  dmem_lane_align u_align (
    .off   (a_addr[1:0]),
    .size  (a_size),
    .uns   (a_uns),
    .wdata (a_wdata),
    .word  (rword),
    .be    (be),
    .wrep  (wrep),
    .rdata (ldata)
  );

  always_ff @(posedge clk_i) begin
    if (do_access & a_write & ~a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[a_idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st              <= S_IDLE;
      cnt             <= 4'd0;
      cap_write       <= 1'b0;
      cap_uns         <= 1'b0;
      cap_addr        <= 32'd0;
      cap_wdata       <= 32'd0;
      cap_size        <= 2'b00;
      bus.req_ready_o <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= 32'd0;
      bus.rsp_err_o   <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          bus.req_ready_o <= 1'b1;
          if (accept) begin
            cap_write       <= bus.req_write_i;
            cap_uns         <= bus.req_unsigned_i;
            cap_addr        <= bus.req_addr_i;
            cap_wdata       <= bus.req_wdata_i;
            cap_size        <= bus.req_size_i;
            cnt             <= CNT_INIT;
            bus.req_ready_o <= 1'b0;
            st <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) st <= S_RESP;
        end
        S_RESP: begin
          if (hs) begin
            st              <= S_IDLE;
            bus.req_ready_o <= 1'b1;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_rdata_o <= 32'd0;
            bus.rsp_err_o   <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
      if (do_access) begin
        bus.rsp_valid_o <= 1'b1;
        bus.rsp_rdata_o <= (a_write | a_err) ? 32'd0 : ldata;
        bus.rsp_err_o   <= a_err;
      end
    end
  end

`ifdef DMEM_STATS_EN
  logic rsp_wr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_wr    <= 1'b0;
      rd_cnt_o  <= 16'd0;
      wr_cnt_o  <= 16'd0;
      err_cnt_o <= 16'd0;
    end else begin
      if (do_access) rsp_wr <= a_write;
      if (hs) begin
        if (bus.rsp_err_o) begin
          if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
        end else if (rsp_wr) begin
          if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
        end else begin
          if (rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench with a byte-array reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  dmem_if bus ();

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DMEM_STATS_EN
    ,
    .rd_cnt_o  (rd_cnt),
    .wr_cnt_o  (wr_cnt),
    .err_cnt_o (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   stall = 0;
  int   n_rd  = 0;
  int   n_wr  = 0;
  int   n_err = 0;
  byte unsigned mb [DEPTH*4];

  always @(posedge clk) cyc <= cyc + 1;

  // Response ready moves 2 time units after the edge so negedge sampling is clean.
  always begin
    @(posedge clk);
    #2;
    if (stall == 1)      bus.rsp_ready_i = 1'b0;
    else if (stall == 2) bus.rsp_ready_i = 1'b1;
    else                 bus.rsp_ready_i = ($urandom_range(3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: latency on each rising rsp_valid, data/err on each handshake.
  logic prev_v = 1'b0;
  exp_t got_e;
  int   acc_c;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid_o === 1'b1 && !prev_v) begin
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got valid want none");
        end else begin
          acc_c = acc_q.pop_front();
          chk("latency", 32'(cyc - acc_c), 32'(LAT - 1));
        end
      end
      if (bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_rsp: got %h want none", bus.rsp_rdata_o);
        end else begin
          got_e = exp_q.pop_front();
          chk("rdata", bus.rsp_rdata_o, got_e.rdata);
          chk("err", 32'(bus.rsp_err_o), 32'(got_e.err));
        end
      end
      prev_v = (bus.rsp_valid_o === 1'b1);
    end
  end

  function automatic exp_t model(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [1:0] sz,
                                 input bit uns, input bit upd);
    exp_t e;
    int nb;
    logic [31:0] v;
    e.err = (sz == 2'b11) || (sz == 2'b01 && addr[0])
         || (sz == 2'b10 && addr[1:0] != 2'b00)
         || ((addr >> 2) >= 32'(DEPTH));
    e.rdata = 32'd0;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (!e.err) begin
      if (wr) begin
        if (upd)
          for (int i = 0; i < nb; i++) mb[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++)
          v = v | (32'(mb[int'(addr) + i]) << (8 * i));
        if (nb < 4 && !uns && v[8*nb-1])
          v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        e.rdata = v;
      end
    end
    if (upd) begin
      if (e.err) n_err++;
      else if (wr) n_wr++;
      else n_rd++;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz,
                       input bit uns, input bit keep);
    exp_t e;
    int n;
    e = model(wr, addr, wd, sz, uns, keep);
    bus.req_valid_i    = 1'b1;
    bus.req_write_i    = wr;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready=%b want 1", bus.req_ready_o);
      bus.req_valid_i = 1'b0;
      return;
    end
    if (keep) begin
      acc_q.push_back(cyc + 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'd0);
`ifdef DMEM_STATS_EN
    chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'd0);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit wr;
    int r;
    int n;
    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'b0;
    bus.req_addr_i     = 32'd0;
    bus.req_wdata_i    = 32'd0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    chk("ready_first_edge", 32'(bus.req_ready_o), 32'd1);

    issue(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 1);
    issue(0, 32'h10, 32'h0, 2'b10, 0, 1);
    issue(1, 32'h20, 32'h80FF7F01, 2'b10, 0, 1);
    issue(0, 32'h23, 32'h0, 2'b00, 0, 1);
    issue(0, 32'h23, 32'h0, 2'b00, 1, 1);
    issue(0, 32'h22, 32'h0, 2'b01, 0, 1);
    issue(0, 32'h20, 32'h0, 2'b01, 1, 1);
    issue(1, 32'h20, 32'h11223344, 2'b10, 0, 1);
    issue(1, 32'h21, 32'h000000AA, 2'b00, 0, 1);
    issue(0, 32'h20, 32'h0, 2'b10, 0, 1);
    issue(0, 32'h21, 32'h0, 2'b01, 0, 1);
    issue(1, 32'h22, 32'hCAFEF00D, 2'b10, 0, 1);
    issue(1, 32'(DEPTH * 4), 32'hCAFEF00D, 2'b10, 0, 1);
    issue(1, 32'h20, 32'hCAFEF00D, 2'b11, 0, 1);
    issue(0, 32'h20, 32'h0, 2'b11, 0, 1);
    issue(0, 32'h20, 32'h0, 2'b10, 0, 1);
    drain();

    stall = 1;
    @(negedge clk);
    issue(0, 32'h10, 32'h0, 2'b10, 0, 1);
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 32'(bus.rsp_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("stall_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
      chk("stall_req_ready", 32'(bus.req_ready_o), 32'd0);
    end
    stall = 2;
    @(negedge clk);
    chk("stall_before_hs", 32'(bus.rsp_valid_o), 32'd1);
    @(negedge clk);
    chk("stall_done_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("stall_done_ready", 32'(bus.req_ready_o), 32'd1);
    stall = 0;
    drain();

    issue(1, 32'h30, 32'h12345678, 2'b10, 0, 1);
    drain();
    issue(1, 32'h30, 32'h00000055, 2'b10, 0, 0);
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    n_rd = 0; n_wr = 0; n_err = 0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 32'h30, 32'h0, 2'b10, 0, 1);
    drain();

    for (int w = 16; w < 32; w++)
      issue(1, 32'(w * 4), $urandom, 2'b10, 0, 1);
    for (int k = 0; k < 120; k++) begin
      r  = $urandom_range(9);
      wr = bit'($urandom_range(1));
      if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(1023));
      else        a = 32'h40 + 32'($urandom_range(63));
      issue(wr, a, $urandom, 2'($urandom_range(3)),
            bit'($urandom_range(1)), 1);
    end
    drain();

`ifdef DMEM_STATS_EN
    chk("stat_rd", 32'(rd_cnt), 32'(n_rd));
    chk("stat_wr", 32'(wr_cnt), 32'(n_wr));
    chk("stat_err", 32'(err_cnt), 32'(n_err));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
